l2_fill_ctrl: RTL and testbench
===============================

# l2_fill_ctrl

Miss-fill controller for the multi-port L2 block cache. Collects miss requests from up to PORTS requesters and grants one at a time by round-robin. Fetches each granted block from the backing chunk memory, then installs it into the cache with a cyclic replacement pointer. One installed fill acknowledges every requester waiting on that block position.

## Interface
Parameters:
- PORTS, 4, number of miss requesters (cache read ports)
- CACHE_SIZE, 16, number of cache entries; sets the replacement pointer range

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- req_valid  in  PORTS  miss pending on port i; held high with stable req_addr[i] until req_ack[i]
- req_addr  in  PORTS x BlockPos  missed block position per port
- req_ack  out  PORTS  one-cycle pulse: block for port i now installed in cache
- mem_req  out  1  one-cycle fetch strobe to chunk memory
- mem_addr  out  BlockPos  position being fetched; stable from mem_req until fill write
- mem_resp_valid  in  1  memory returns data (one-cycle pulse)
- mem_resp_data  in  BlockType  fetched block
- wr_en  out  1  one-cycle cache install strobe
- wr_idx  out  $clog2(CACHE_SIZE)  entry to overwrite
- wr_tag  out  BlockPos  tag to install (equals mem_addr)
- wr_data  out  BlockType  block to install
- busy  out  1  high in any state other than IDLE
- fill_count  out  16  number of completed fills; wraps at 2^16

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - If any req_valid is high, grant the first set port at or after rr_ptr (wrapping modulo PORTS).
  - Latch req_addr[grant] into mem_addr and go to REQ.
  - Set rr_ptr = (grant+1) mod PORTS.
  - Stay in IDLE if there are no requests.
- REQ: mem_req=1 for exactly this cycle; go to WAIT unconditionally.
- WAIT:
  - Stay until mem_resp_valid=1.
  - On the response, latch mem_resp_data into wr_data and go to WRITE.
- WRITE:
  - wr_en=1, wr_idx=repl_ptr, wr_tag=mem_addr.
  - Set req_ack[i]=1 for every port with req_valid[i]=1 and req_addr[i]==mem_addr (coalescing).
  - repl_ptr advances to (repl_ptr+1) mod CACHE_SIZE; CACHE_SIZE need not be a power of two.
  - fill_count increments.
  - Return to IDLE.
- mem_resp_valid in IDLE, REQ or WRITE is ignored; no data is latched and there is no state change.
- Requester drops req_valid before its ack: the fill still completes and installs. No ack is issued to the dropped port. Another port matching the address is still acked.
- A port whose req_valid rises during REQ/WAIT with the in-flight address is acked in WRITE if its request is still high then.
- Address comparison is full-width equality over all three signed coordinates of BlockPos.
- Invalid-tag sentinel positions are never requested. Behaviour is don't-care if they are.
- The controller never checks whether the block is already cached; requesters issue misses only.

## Timing
- Reset (asynchronous assert; synchronous release on clk_in) drives:
  - state=IDLE, rr_ptr=0, repl_ptr=0, fill_count=0
  - req_ack=0, mem_req=0, wr_en=0, busy=0
  - mem_addr=0, wr_idx=0, wr_tag=0, wr_data=BLOCK_AIR
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Grant in IDLE at cycle t:
  - mem_req high at t+1, busy high from t+1.
  - Earliest accepted mem_resp_valid is t+2.
- Response accepted at cycle r:
  - wr_en and req_ack high at r+1.
  - IDLE at r+2; the next grant can occur at r+2.
- Minimum grant-to-grant period is 4 cycles.
- Reset mid-operation:
  - The in-flight fill is abandoned; no wr_en and no req_ack are issued for it.
  - A late mem_resp_valid after reset is ignored because the FSM is in IDLE.
- wr_data, wr_tag and wr_idx are stable throughout WRITE. They hold their last values in other states, which is a don't-care for the cache.

## Test plan
- Reset, then req_valid=4'b0001, addr (1,2,3); memory answers 3 cycles after mem_req.
  - Required: mem_req one cycle with mem_addr=(1,2,3).
  - Required: wr_en one cycle with wr_idx=0, wr_tag=(1,2,3), wr_data=response.
  - Required: req_ack=4'b0001 in the same cycle as wr_en; fill_count=1.
- Ports 0, 1 and 3 request distinct addresses simultaneously, held until ack.
  - Required: grant order 0, 1, 3.
  - Then port 0 requests again: it is served after 3.
- Ports 1 and 2 request the same address (-4,0,7).
  - Required: exactly one mem_req.
  - Required: req_ack=4'b0110 in one cycle with a single wr_en.
- Run CACHE_SIZE+2 sequential fills.
  - Required: wr_idx sequence 0…15, 0, 1; fill_count=18.
- Assert mem_resp_valid while in IDLE, then assert rst_in during WAIT and deliver a response afterwards.
  - Required: no wr_en, no req_ack, state IDLE.
  - Required: all outputs at their reset values.
- Port 2 drops req_valid during WAIT.
  - Required: wr_en still fires with no ack to port 2.
  - Required: the next grant follows rr_ptr=3.

Source files
------------

// File: rtl/l2_fill_ctrl_if.sv
// Shared block types and the requester/memory/cache handshake bundle
// for the L2 miss-fill controller.
package l2_fill_pkg;
  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic signed [7:0] z;
  } block_pos_t;

  typedef logic [15:0] block_type_t;

  localparam block_type_t BLOCK_AIR = 16'h0000;
endpackage

interface l2_fill_ctrl_if #(
  parameter int PORTS      = 4,
  parameter int CACHE_SIZE = 16
);
  import l2_fill_pkg::*;

  localparam int IDX_W = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;

  logic [PORTS-1:0] req_valid;
  block_pos_t       req_addr [PORTS];
  logic [PORTS-1:0] req_ack;
  logic             mem_req;
  block_pos_t       mem_addr;
  logic             mem_resp_valid;
  block_type_t      mem_resp_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  block_pos_t       wr_tag;
  block_type_t      wr_data;
  logic             busy;
  logic [15:0]      fill_count;

  // slave: the fill controller itself
  modport slave (
    input  req_valid, req_addr, mem_resp_valid, mem_resp_data,
    output req_ack, mem_req, mem_addr, wr_en, wr_idx, wr_tag, wr_data,
           busy, fill_count
  );

  // master: requesters, chunk memory and cache seen as one environment
  modport master (
    output req_valid, req_addr, mem_resp_valid, mem_resp_data,
    input  req_ack, mem_req, mem_addr, wr_en, wr_idx, wr_tag, wr_data,
           busy, fill_count
  );
endinterface

// File: rtl/l2_fill_ctrl.sv
// L2 miss-fill controller: round-robin grant over miss requesters, fetch from
// chunk memory, install with a cyclic replacement pointer, coalesced acks.
module l2_fill_ctrl
  import l2_fill_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int CACHE_SIZE = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  l2_fill_ctrl_if.slave bus
);

  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int IDX_W = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] repl_ptr_reg;
  logic [15:0]      fill_count_reg;
  logic [PORTS-1:0] req_ack_reg;
  logic             mem_req_reg;
  logic             wr_en_reg;
  block_pos_t       mem_addr_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  block_pos_t       wr_tag_reg;
  block_type_t      wr_data_reg;

  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] repl_ptr_next;
  logic [PORTS-1:0] match_vec;
  int               rot_sum;

  // Every still-pending requester for the in-flight block gets acked together.
  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_match
      assign match_vec[gi] = bus.req_valid[gi] && (bus.req_addr[gi] == mem_addr_reg);
    end
  endgenerate

  // Search downward so the lowest rotation offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rot_sum     = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      rot_sum = int'(rr_ptr_reg) + k;
      if (rot_sum >= PORTS) begin
        rot_sum = rot_sum - PORTS;
      end
      if (bus.req_valid[PTR_W'(rot_sum)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(rot_sum);
      end
    end
  end

  assign rr_ptr_next   = (grant_idx == PTR_W'(PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign repl_ptr_next = (repl_ptr_reg == IDX_W'(CACHE_SIZE - 1)) ? '0
                                                                 : repl_ptr_reg + IDX_W'(1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      repl_ptr_reg   <= '0;
      fill_count_reg <= '0;
      req_ack_reg    <= '0;
      mem_req_reg    <= 1'b0;
      wr_en_reg      <= 1'b0;
      mem_addr_reg   <= '0;
      wr_idx_reg     <= '0;
      wr_tag_reg     <= '0;
      wr_data_reg    <= BLOCK_AIR;
    end else begin
      mem_req_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      req_ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            mem_addr_reg <= bus.req_addr[grant_idx];
            rr_ptr_reg   <= rr_ptr_next;
            mem_req_reg  <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          // Install strobes and acks are registered here so they appear in WRITE.
          if (bus.mem_resp_valid) begin
            wr_data_reg <= bus.mem_resp_data;
            wr_tag_reg  <= mem_addr_reg;
            wr_idx_reg  <= repl_ptr_reg;
            wr_en_reg   <= 1'b1;
            req_ack_reg <= match_vec;
            state_reg   <= WRITE;
          end
        end
        WRITE: begin
          repl_ptr_reg   <= repl_ptr_next;
          fill_count_reg <= fill_count_reg + 16'd1;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack    = req_ack_reg;
  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_idx     = wr_idx_reg;
  assign bus.wr_tag     = wr_tag_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.fill_count = fill_count_reg;

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Scoreboard bench for l2_fill_ctrl: stimulus pushes expected fetches/installs,
// a negedge monitor pops and compares whenever mem_req or wr_en appears.
module tb_l2_fill_ctrl;
  import l2_fill_pkg::*;

  localparam int PORTS      = 4;
  localparam int CACHE_SIZE = 16;
  localparam int IDX_W      = 4;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    block_pos_t       tag;
    block_type_t      data;
    logic [PORTS-1:0] ack;
  } wr_exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  l2_fill_ctrl_if #(.PORTS(PORTS), .CACHE_SIZE(CACHE_SIZE)) bus ();

  l2_fill_ctrl #(.PORTS(PORTS), .CACHE_SIZE(CACHE_SIZE)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  block_pos_t  exp_mem_q [$];
  wr_exp_t     exp_wr_q  [$];
  int          tests = 0;
  int          fails = 0;
  int          exp_idx = 0;
  block_type_t last_data = BLOCK_AIR;

  function automatic block_pos_t mk(input int x, input int y, input int z);
    block_pos_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    p.z = 8'(z);
    return p;
  endfunction

  // Chunk memory content model: a fixed function of the block position.
  function automatic block_type_t data_of(input block_pos_t p);
    return {p.x ^ p.z, p.y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_fill(input block_pos_t a, input logic [PORTS-1:0] ack, input bit with_write);
    wr_exp_t e;
    exp_mem_q.push_back(a);
    if (with_write) begin
      e.idx  = IDX_W'(exp_idx);
      e.tag  = a;
      e.data = data_of(a);
      e.ack  = ack;
      exp_wr_q.push_back(e);
      exp_idx = (exp_idx + 1) % CACHE_SIZE;
      last_data = e.data;
    end
  endtask

  // Monitor: the only place fetch strobes and installs are compared.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.mem_req) begin
        if (exp_mem_q.size() == 0) begin
          chk("unexpected_mem_req", 64'(bus.mem_addr), 64'(0));
          if (bus.mem_addr == '0) chk("unexpected_mem_req_strobe", 64'(1), 64'(0));
        end else begin
          chk("mem_addr", 64'(bus.mem_addr), 64'(exp_mem_q.pop_front()));
        end
      end
      if (bus.wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_wr_en", 64'(bus.wr_en), 64'(0));
        end else begin
          wr_exp_t e;
          e = exp_wr_q.pop_front();
          $display("[TB] fill idx=%0d tag=(%0d,%0d,%0d) data=%h ack=%b",
                   bus.wr_idx, bus.wr_tag.x, bus.wr_tag.y, bus.wr_tag.z, bus.wr_data, bus.req_ack);
          chk("wr_idx",  64'(bus.wr_idx),  64'(e.idx));
          chk("wr_tag",  64'(bus.wr_tag),  64'(e.tag));
          chk("wr_data", 64'(bus.wr_data), 64'(e.data));
          chk("req_ack", 64'(bus.req_ack), 64'(e.ack));
        end
      end else if (bus.req_ack != '0) begin
        chk("ack_without_wr_en", 64'(bus.req_ack), 64'(0));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.req_valid = '0;
    bus.mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    exp_idx = 0;
  endtask

  task automatic wait_mem_req(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bus.mem_req && n < 50);
    chk(name, 64'(bus.mem_req), 64'(1));
  endtask

  task automatic mem_serve(input int nfills, input int lat);
    for (int k = 0; k < nfills; k++) begin
      wait_mem_req("mem_req_timeout");
      repeat (lat) @(negedge clk_in);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = data_of(bus.mem_addr);
      @(negedge clk_in);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 16'hDEAD;
    end
  endtask

  task automatic wait_acks(input logic [PORTS-1:0] mask, input string name);
    logic [PORTS-1:0] pending;
    int n;
    pending = mask;
    n = 0;
    while (pending != '0 && n < 200) begin
      @(negedge clk_in);
      n++;
      pending       = pending & ~bus.req_ack;
      bus.req_valid = bus.req_valid & ~bus.req_ack;
    end
    chk(name, 64'(pending), 64'(0));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},       64'(bus.busy),       64'(0));
    chk({tag, "_mem_req"},    64'(bus.mem_req),    64'(0));
    chk({tag, "_wr_en"},      64'(bus.wr_en),      64'(0));
    chk({tag, "_req_ack"},    64'(bus.req_ack),    64'(0));
    chk({tag, "_mem_addr"},   64'(bus.mem_addr),   64'(0));
    chk({tag, "_wr_idx"},     64'(bus.wr_idx),     64'(0));
    chk({tag, "_wr_tag"},     64'(bus.wr_tag),     64'(0));
    chk({tag, "_wr_data"},    64'(bus.wr_data),    64'(BLOCK_AIR));
    chk({tag, "_fill_count"}, 64'(bus.fill_count), 64'(0));
  endtask

  initial begin
    bus.req_valid      = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 16'hDEAD;
    for (int i = 0; i < PORTS; i++) bus.req_addr[i] = '0;

    // T1: single fill, memory answers 3 cycles after mem_req
    do_reset();
    @(negedge clk_in);
    chk_reset_values("t1_rst");
    expect_fill(mk(1, 2, 3), 4'b0001, 1'b1);
    bus.req_addr[0]  = mk(1, 2, 3);
    bus.req_valid[0] = 1'b1;
    fork
      mem_serve(1, 3);
      begin
        @(negedge clk_in);
        chk("t1_busy_after_grant", 64'(bus.busy), 64'(1));
        chk("t1_mem_req_after_grant", 64'(bus.mem_req), 64'(1));
      end
      wait_acks(4'b0001, "t1_ack_timeout");
    join
    @(negedge clk_in);
    chk("t1_fill_count", 64'(bus.fill_count), 64'(1));
    chk("t1_idle", 64'(bus.busy), 64'(0));

    // T2: ports 0,1,3 at once, then port 0 again -> order 0,1,3,0
    do_reset();
    expect_fill(mk(10, 0, 0), 4'b0001, 1'b1);
    expect_fill(mk(11, 1, -1), 4'b0010, 1'b1);
    expect_fill(mk(13, 3, -3), 4'b1000, 1'b1);
    expect_fill(mk(20, -5, 5), 4'b0001, 1'b1);
    bus.req_addr[0] = mk(10, 0, 0);
    bus.req_addr[1] = mk(11, 1, -1);
    bus.req_addr[3] = mk(13, 3, -3);
    bus.req_valid   = 4'b1011;
    fork
      mem_serve(4, 2);
      begin
        wait_acks(4'b0001, "t2_ack0_timeout");
        bus.req_addr[0]  = mk(20, -5, 5);
        bus.req_valid[0] = 1'b1;
        wait_acks(4'b1011, "t2_rest_timeout");
      end
    join

    // T3: ports 1 and 2 share (-4,0,7): one fetch, ack 0110
    expect_fill(mk(-4, 0, 7), 4'b0110, 1'b1);
    bus.req_addr[1] = mk(-4, 0, 7);
    bus.req_addr[2] = mk(-4, 0, 7);
    bus.req_valid   = 4'b0110;
    fork
      mem_serve(1, 2);
      wait_acks(4'b0110, "t3_ack_timeout");
    join
    repeat (3) @(negedge clk_in);
    chk("t3_single_fetch", 64'(exp_mem_q.size()), 64'(0));

    // T4: CACHE_SIZE+2 fills, replacement pointer wraps
    do_reset();
    for (int i = 0; i < CACHE_SIZE + 2; i++) begin
      expect_fill(mk(i, -i, 2), 4'(1 << (i % PORTS)), 1'b1);
      bus.req_addr[i % PORTS]  = mk(i, -i, 2);
      bus.req_valid[i % PORTS] = 1'b1;
      fork
        mem_serve(1, 1);
        wait_acks(4'(1 << (i % PORTS)), "t4_ack_timeout");
      join
    end
    @(negedge clk_in);
    chk("t4_fill_count", 64'(bus.fill_count), 64'(18));

    // T5: stray response in IDLE, then reset during WAIT and a late response
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 16'h1234;
    @(negedge clk_in);
    bus.mem_resp_valid = 1'b0;
    @(negedge clk_in);
    chk("t5_stray_busy", 64'(bus.busy), 64'(0));
    chk("t5_stray_no_latch", 64'(bus.wr_data), 64'(last_data));
    expect_fill(mk(7, 7, -7), 4'b0000, 1'b0);
    bus.req_addr[0]  = mk(7, 7, -7);
    bus.req_valid[0] = 1'b1;
    wait_mem_req("t5_mem_req_timeout");
    @(negedge clk_in);
    bus.req_valid = '0;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_idx = 0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 16'hBEEF;
    @(negedge clk_in);
    bus.mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_no_wr_en", 64'(bus.wr_en), 64'(0));
      chk("t5_no_req_ack", 64'(bus.req_ack), 64'(0));
      @(negedge clk_in);
    end
    chk_reset_values("t5_post");

    // T6: port 2 drops during WAIT; install still happens, next grant starts at 3
    expect_fill(mk(2, 2, 2), 4'b0000, 1'b1);
    bus.req_addr[2]  = mk(2, 2, 2);
    bus.req_valid[2] = 1'b1;
    fork
      mem_serve(1, 3);
      begin
        wait_mem_req("t6_mem_req_timeout");
        @(negedge clk_in);
        bus.req_valid[2] = 1'b0;
      end
    join
    repeat (2) @(negedge clk_in);
    chk("t6_fill_count", 64'(bus.fill_count), 64'(1));
    expect_fill(mk(3, 0, 3), 4'b1000, 1'b1);
    expect_fill(mk(0, 3, 0), 4'b0001, 1'b1);
    bus.req_addr[0] = mk(0, 3, 0);
    bus.req_addr[3] = mk(3, 0, 3);
    bus.req_valid   = 4'b1001;
    fork
      mem_serve(2, 2);
      wait_acks(4'b1001, "t6_ack_timeout");
    join
    repeat (3) @(negedge clk_in);

    chk("end_mem_queue_empty", 64'(exp_mem_q.size()), 64'(0));
    chk("end_wr_queue_empty",  64'(exp_wr_q.size()),  64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
